// File: rtl/nms_stream.sv
// nms_stream: streaming 3x3 non-maximum suppression over FAST corner scores.
// Two line buffers feed a 3x3 window; one registered result per emitted center.
module nms_stream #(
    parameter int SCORE_WIDTH   = 8,
    parameter int IMG_WIDTH     = 640,
    parameter int IMG_HEIGHT    = 480,
    parameter int TIE_MODE      = 0,
    parameter int NEIGHBOR_GATE = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_sof,
    input  logic                          in_is_corner,
    input  logic [SCORE_WIDTH-1:0]        in_score,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_corner_is_max,
    output logic [SCORE_WIDTH-1:0]        out_score,
    output logic [$clog2(IMG_WIDTH)-1:0]  out_x,
    output logic [$clog2(IMG_HEIGHT)-1:0] out_y
);
    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam int PW = SCORE_WIDTH + 1;
    localparam logic [XW-1:0] XMAX = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] YMAX = YW'(IMG_HEIGHT - 1);

    logic [PW-1:0] r_lb0 [IMG_WIDTH];
    logic [PW-1:0] r_lb1 [IMG_WIDTH];
    logic [PW-1:0] r_ul, r_u, r_l, r_c, r_ll, r_d;
    logic [XW-1:0] r_x, r_ox;
    logic [YW-1:0] r_y, r_oy;
    logic          r_ov, r_max;
    logic [SCORE_WIDTH-1:0] r_score;

    logic [XW-1:0] w_x, w_cx, w_x_nxt;
    logic [YW-1:0] w_y, w_cy, w_y_nxt;
    logic [PW-1:0] w_top, w_mid, w_bot;
    logic [SCORE_WIDTH-1:0] w_cs;
    logic w_acc, w_emit, w_early, w_late, w_max;

    function automatic logic [SCORE_WIDTH-1:0] f_nsc(input logic [PW-1:0] p);
        if (NEIGHBOR_GATE != 0 && !p[PW-1]) return '0;
        return p[SCORE_WIDTH-1:0];
    endfunction

    function automatic logic f_later(input logic [SCORE_WIDTH-1:0] c,
                                     input logic [SCORE_WIDTH-1:0] n);
        if (TIE_MODE != 0) return c >= n;
        return c > n;
    endfunction

    assign in_ready = !r_ov || out_ready;
    assign w_acc    = in_valid && in_ready;

    // sof forces the accepted pixel to (0,0) whatever the counters say
    assign w_x     = in_sof ? '0 : r_x;
    assign w_y     = in_sof ? '0 : r_y;
    assign w_x_nxt = (w_x == XMAX) ? '0 : w_x + 1'b1;
    assign w_y_nxt = (w_x != XMAX) ? w_y :
                     (w_y == YMAX) ? '0 : w_y + 1'b1;
    assign w_cx    = w_x - 1'b1;
    assign w_cy    = w_y - 1'b1;

    // incoming column x: rows y-2, y-1, y
    assign w_top = r_lb1[w_x];
    assign w_mid = r_lb0[w_x];
    assign w_bot = {in_is_corner, in_score};
    assign w_cs  = r_c[SCORE_WIDTH-1:0];

    assign w_early = (w_cs > f_nsc(r_ul)) && (w_cs > f_nsc(r_u)) &&
                     (w_cs > f_nsc(w_top)) && (w_cs > f_nsc(r_l));
    assign w_late  = f_later(w_cs, f_nsc(w_mid)) &&
                     f_later(w_cs, f_nsc(r_ll)) &&
                     f_later(w_cs, f_nsc(r_d)) &&
                     f_later(w_cs, f_nsc(w_bot));
    assign w_emit  = w_acc && (w_x != '0) && (w_y != '0);
    assign w_max   = r_c[PW-1] && w_early && w_late &&
                     (w_cx != '0) && (w_cy != '0);

    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_lb0[w_x] <= w_bot;
            r_lb1[w_x] <= w_mid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x  <= '0;
            r_y  <= '0;
            r_ul <= '0;
            r_u  <= '0;
            r_l  <= '0;
            r_c  <= '0;
            r_ll <= '0;
            r_d  <= '0;
        end else if (w_acc) begin
            r_x  <= w_x_nxt;
            r_y  <= w_y_nxt;
            r_ul <= r_u;
            r_u  <= w_top;
            r_l  <= r_c;
            r_c  <= w_mid;
            r_ll <= r_d;
            r_d  <= w_bot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ov    <= 1'b0;
            r_max   <= 1'b0;
            r_score <= '0;
            r_ox    <= '0;
            r_oy    <= '0;
        end else if (in_ready) begin
            r_ov <= w_emit;
            if (w_emit) begin
                r_max   <= w_max;
                r_score <= w_cs;
                r_ox    <= w_cx;
                r_oy    <= w_cy;
            end
        end
    end

    assign out_valid         = r_ov;
    assign out_corner_is_max = r_max;
    assign out_score         = r_score;
    assign out_x             = r_ox;
    assign out_y             = r_oy;
endmodule
